// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch run/pause/lap/clear controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } sw_state_e;

  localparam int TENTHS_MAX  = 9;
  localparam int CLK_HZ_DEF  = 50_000_000;
  localparam int TICK_HZ_DEF = 10;
  localparam int SEC_MAX_DEF = 999;

endpackage

// File: rtl/stopwatch_prescaler.sv
// Modulo-DIV prescaler with enable and synchronous clear; tc marks the wrap cycle.
module stopwatch_prescaler
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM, tenths/seconds counters, lap capture and display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEF,
  parameter int TICK_HZ = TICK_HZ_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int SEC_W   = $clog2(SEC_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start_stop,
  input  logic             btn_lap,
  input  logic             btn_clear,
  output logic             running,
  output logic             lap_active,
  output logic             tick,
  output logic [3:0]       tenths,
  output logic [SEC_W-1:0] seconds,
  output logic [3:0]       disp_tenths,
  output logic [SEC_W-1:0] disp_seconds,
  output logic             overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  localparam logic [3:0]       TEN_LAST = 4'(TENTHS_MAX);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);

  sw_state_e        state_q;
  logic [3:0]       tenths_q, lap_tenths_q;
  logic [SEC_W-1:0] sec_q, lap_sec_q;
  logic             tick_q, ovf_q, running_q, lap_q;
  logic             cnt_en, clr, tc;

  // Counting and clearing both follow the pre-edge state.
  assign cnt_en = (state_q == RUN) || (state_q == LAP);
  assign clr    = (state_q == PAUSE) && btn_clear;

  stopwatch_prescaler #(.DIV(DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (clr),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tenths_q     <= '0;
      sec_q        <= '0;
      lap_tenths_q <= '0;
      lap_sec_q    <= '0;
      tick_q       <= 1'b0;
      ovf_q        <= 1'b0;
      running_q    <= 1'b0;
      lap_q        <= 1'b0;
    end else begin
      tick_q <= tc;
      if (tc) begin
        if (tenths_q == TEN_LAST) begin
          tenths_q <= '0;
          if (sec_q == SEC_LAST) begin
            sec_q <= '0;
            ovf_q <= 1'b1;
          end else begin
            sec_q <= sec_q + 1'b1;
          end
        end else begin
          tenths_q <= tenths_q + 4'd1;
        end
      end
      case (state_q)
        IDLE: if (btn_start_stop) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: if (btn_start_stop) begin
          state_q   <= PAUSE;
          running_q <= 1'b0;
        end else if (btn_lap) begin
          state_q      <= LAP;
          lap_q        <= 1'b1;
          lap_tenths_q <= tenths_q;
          lap_sec_q    <= sec_q;
        end
        LAP: if (btn_start_stop) begin
          state_q   <= PAUSE;
          running_q <= 1'b0;
          lap_q     <= 1'b0;
        end else if (btn_lap) begin
          state_q <= RUN;
          lap_q   <= 1'b0;
        end
        PAUSE: if (btn_clear) begin
          state_q      <= IDLE;
          tenths_q     <= '0;
          sec_q        <= '0;
          lap_tenths_q <= '0;
          lap_sec_q    <= '0;
          ovf_q        <= 1'b0;
        end else if (btn_start_stop) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign running      = running_q;
  assign lap_active   = lap_q;
  assign tick         = tick_q;
  assign tenths       = tenths_q;
  assign seconds      = sec_q;
  assign overflow     = ovf_q;
  assign disp_tenths  = lap_q ? lap_tenths_q : tenths_q;
  assign disp_seconds = lap_q ? lap_sec_q    : sec_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (SEC_MAX 999 and 2) checked every cycle against an elapsed-cycle model.
module tb_stopwatch_ctrl;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss[2], lp[2], cl[2];

  logic       run0, run1, lapa0, lapa1, tick0, tick1, ovf0, ovf1;
  logic [3:0] ten0, ten1, dten0, dten1;
  logic [9:0] sec0, dsec0;
  logic [1:0] sec1, dsec1;

  stopwatch_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .SEC_MAX(999)) u0 (
    .clk(clk), .rst_n(rst_n), .btn_start_stop(ss[0]), .btn_lap(lp[0]), .btn_clear(cl[0]),
    .running(run0), .lap_active(lapa0), .tick(tick0), .tenths(ten0), .seconds(sec0),
    .disp_tenths(dten0), .disp_seconds(dsec0), .overflow(ovf0)
  );

  stopwatch_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .SEC_MAX(2)) u1 (
    .clk(clk), .rst_n(rst_n), .btn_start_stop(ss[1]), .btn_lap(lp[1]), .btn_clear(cl[1]),
    .running(run1), .lap_active(lapa1), .tick(tick1), .tenths(ten1), .seconds(sec1),
    .disp_tenths(dten1), .disp_seconds(dsec1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 run, 2 lap, 3 pause; rc = clock edges spent counting.
  int   smax[2];
  int   mode[2];
  int   rc[2];
  int   lapt[2];
  logic tick_e[2];
  int   ncmp = 0;
  int   nerr = 0;
  int   tickcnt0 = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d]: got %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  task automatic check_inst(input int k);
    int t, ten, sec, dt, ds;
    logic lapm, ovf;
    t    = rc[k] / DIV;
    ten  = t % 10;
    sec  = (t / 10) % (smax[k] + 1);
    ovf  = (t >= 10 * (smax[k] + 1));
    lapm = (mode[k] == 2);
    dt   = lapm ? lapt[k] % 10 : ten;
    ds   = lapm ? (lapt[k] / 10) % (smax[k] + 1) : sec;
    chk("running",  k, k ? run1  : run0,  (mode[k] == 1 || mode[k] == 2));
    chk("lap",      k, k ? lapa1 : lapa0, lapm);
    chk("tick",     k, k ? tick1 : tick0, tick_e[k]);
    chk("tenths",   k, k ? ten1  : ten0,  ten);
    chk("seconds",  k, k ? 32'(sec1)  : 32'(sec0),  sec);
    chk("dtenths",  k, k ? dten1 : dten0, dt);
    chk("dseconds", k, k ? 32'(dsec1) : 32'(dsec0), ds);
    chk("overflow", k, k ? ovf1  : ovf0,  ovf);
  endtask

  task automatic model_step(input int k);
    int pre;
    logic cnt;
    pre = rc[k];
    cnt = (mode[k] == 1 || mode[k] == 2);
    if (cnt) rc[k]++;
    tick_e[k] = cnt && (rc[k] % DIV == 0);
    case (mode[k])
      0: if (ss[k]) mode[k] = 1;
      1: if (ss[k]) mode[k] = 3;
         else if (lp[k]) begin mode[k] = 2; lapt[k] = pre / DIV; end
      2: if (ss[k]) mode[k] = 3;
         else if (lp[k]) mode[k] = 1;
      default: if (cl[k]) begin mode[k] = 0; rc[k] = 0; lapt[k] = 0; end
               else if (ss[k]) mode[k] = 1;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin ss[k] = 1'b0; lp[k] = 1'b0; cl[k] = 1'b0; end
    if (tick0) tickcnt0++;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin mode[k] = 0; rc[k] = 0; lapt[k] = 0; tick_e[k] = 1'b0; end
    check_inst(0);
    check_inst(1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_inst(0);
    check_inst(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    smax[0] = 999;
    smax[1] = 2;
    for (int k = 0; k < 2; k++) begin ss[k] = 1'b0; lp[k] = 1'b0; cl[k] = 1'b0; end
    @(negedge clk);
    do_reset();

    // Reset asserted mid-run, then idle with no ticks.
    ss[0] = 1'b1; cyc();
    run(37);
    do_reset();
    tickcnt0 = 0;
    run(20);
    chk("idle_ticks", 0, tickcnt0, 0);

    // Free run for 250 cycles.
    ss[0] = 1'b1; cyc();
    tickcnt0 = 0;
    run(250);
    chk("run_ticks", 0, tickcnt0, 25);
    chk("run_tenths", 0, ten0, 5);
    chk("run_seconds", 0, sec0, 2);
    chk("run_running", 0, run0, 1);
    ss[0] = 1'b1; cyc();
    cl[0] = 1'b1; cyc();

    // Pause holds the partial tenth; resume finishes it.
    ss[0] = 1'b1; cyc();
    run(6);
    ss[0] = 1'b1; cyc();
    tickcnt0 = 0;
    run(100);
    chk("pause_ticks", 0, tickcnt0, 0);
    ss[0] = 1'b1; cyc();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n++;
      if (tick0) break;
    end
    chk("resume_latency", 0, n, 3);
    ss[0] = 1'b1; cyc();
    cl[0] = 1'b1; cyc();

    // Lap capture at 1.3 s while live runs to 2.0 s.
    ss[0] = 1'b1; cyc();
    run(130);
    lp[0] = 1'b1; cyc();
    chk("lap_dten", 0, dten0, 3);
    chk("lap_dsec", 0, dsec0, 1);
    run(69);
    chk("lap_live_ten", 0, ten0, 0);
    chk("lap_live_sec", 0, sec0, 2);
    chk("lap_hold_dsec", 0, dsec0, 1);
    lp[0] = 1'b1; cyc();
    chk("lap_release", 0, lapa0, 0);
    run(5);
    lp[0] = 1'b1; cyc();
    run(4);
    ss[0] = 1'b1; cyc();
    chk("lap_stop_lap", 0, lapa0, 0);
    chk("lap_stop_run", 0, run0, 0);

    // Stop in the terminal-count cycle still produces that tick.
    cl[0] = 1'b1; cyc();
    ss[0] = 1'b1; cyc();
    run(9);
    ss[0] = 1'b1; cyc();
    chk("tc_stop_tick", 0, tick0, 1);
    chk("tc_stop_ten", 0, ten0, 1);

    // Clear ignored in RUN; clear beats start_stop in PAUSE.
    ss[0] = 1'b1; cyc();
    run(3);
    cl[0] = 1'b1; cyc();
    chk("clr_in_run", 0, run0, 1);
    run(3);
    ss[0] = 1'b1; cyc();
    ss[0] = 1'b1; cl[0] = 1'b1; cyc();
    chk("clr_prio_run", 0, run0, 0);
    chk("clr_prio_ten", 0, ten0, 0);
    chk("clr_prio_sec", 0, sec0, 0);
    run(12);

    // Seconds wrap with SEC_MAX=2.
    ss[1] = 1'b1; cyc();
    run(300);
    chk("ovf_set", 1, ovf1, 1);
    chk("ovf_sec", 1, sec1, 0);
    chk("ovf_ten", 1, ten1, 0);
    chk("ovf_run", 1, run1, 1);
    run(15);
    chk("ovf_counting", 1, ten1, 1);
    chk("ovf_sticky", 1, ovf1, 1);
    ss[1] = 1'b1; cyc();
    cl[1] = 1'b1; cyc();
    chk("ovf_cleared", 1, ovf1, 0);

    // Random button traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 2; k++) begin
        ss[k] = ($urandom_range(0, 15) == 0);
        lp[k] = ($urandom_range(0, 9) == 0);
        cl[k] = ($urandom_range(0, 11) == 0);
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
